fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_skid.sv | 27 ++
 rtl/fetch_stage.sv | 69 ++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline types and constants for the fetch stage
package fetch_stage_pkg;
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_bus_t;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory request/response channel
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding register for a response that arrives while decode is stalled
module fetch_skid import fetch_stage_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  if_id_bus_t push_data,
  output logic       full,
  output if_id_bus_t data
);
  logic       full_q;
  if_id_bus_t data_q;
  // clear beats push beats pop; the payload needs no reset since full_q guards it
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      full_q <= 1'b0;
    end else if (push) begin
      full_q <= 1'b1;
      data_q <= push_data;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end
  assign full = full_q;
  assign data = data_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch feeding the IF/ID register
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output if_id_bus_t           if_id_bus_out,
  output logic                 if_id_valid
);
  localparam if_id_bus_t NOP_BUS = '{instr: NOP_INSTR, pc: 32'h0};
  fetch_state_t state_q;
  logic [31:0]  pc_q, req_pc_q;
  if_id_bus_t   bus_q, bus_d, rsp_bus, skid_data;
  logic         valid_q, valid_d, rsp, skid_full;
  assign rsp     = state_q == WAIT && imem.imem_rvalid;
  assign rsp_bus = '{instr: imem.imem_rdata, pc: req_pc_q};
  assign imem.imem_req  = state_q == IDLE && !skid_full && !redirect_valid && reset;
  assign imem.imem_addr = pc_q;
  fetch_skid u_skid (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (rsp && stall && !redirect_valid),
    .pop       (skid_full && !stall && !redirect_valid),
    .push_data (rsp_bus),
    .full      (skid_full),
    .data      (skid_data)
  );
  // IF/ID next value: a buffered word drains before a fresh response, otherwise a bubble
  always_comb begin
    bus_d   = stall ? bus_q : skid_full ? skid_data : rsp ? rsp_bus : NOP_BUS;
    valid_d = stall ? valid_q : skid_full || rsp;
  end
  // request FSM, pc and IF/ID register; a redirect overrides stall and kills any in-flight word
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
      bus_q    <= NOP_BUS;
      valid_q  <= 1'b0;
    end else if (redirect_valid) begin
      pc_q    <= word_align(redirect_pc);
      bus_q   <= NOP_BUS;
      valid_q <= 1'b0;
      if (state_q != IDLE) state_q <= imem.imem_rvalid ? IDLE : DISCARD;
    end else begin
      bus_q   <= bus_d;
      valid_q <= valid_d;
      case (state_q)
        IDLE: if (imem.imem_req && imem.imem_ready) begin
          state_q  <= WAIT;
          req_pc_q <= pc_q;
          pc_q     <= pc_q + 32'd4;
        end
        WAIT:    if (imem.imem_rvalid) state_q <= IDLE;
        DISCARD: if (imem.imem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign if_id_bus_out = bus_q;
  assign if_id_valid   = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, directed corner sequences and a randomized queue-model run
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  typedef struct {
    logic [4:0]  in;
    logic [31:0] rpc, rdata;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr, pc;
  } vec_t;
  localparam logic [31:0] N = NOP_INSTR_C;
  logic clk = 1'b0;
  logic rst_n, stall, redirect_valid, rst2;
  logic [31:0] redirect_pc;
  if_id_bus_t bus, bus2, exp_e, snap;
  logic valid, valid2, snap_v, outst, disc, p_redir, p_hold, s, d, rdy, rv;
  logic [31:0] mpc, rq_pc, rpc, rdat;
  int unsigned cd;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vt[20];
  if_id_bus_t q[$];
  fetch_stage_if imem();
  fetch_stage_if imem2();
  always #5 clk = ~clk;
  fetch_stage dut (
    .clock(clk), .reset(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem(imem), .if_id_bus_out(bus), .if_id_valid(valid)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clk), .reset(rst2), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem(imem2), .if_id_bus_out(bus2), .if_id_valid(valid2)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  // in = {reset, stall, redirect_valid, imem_ready, imem_rvalid}
  task automatic drive(input logic [4:0] in, input logic [31:0] p, input logic [31:0] dt);
    @(negedge clk);
    {rst_n, stall, redirect_valid, imem.imem_ready, imem.imem_rvalid} = in;
    redirect_pc = p;
    imem.imem_rdata = dt;
    #1;
  endtask
  task automatic chk_out(input string nm, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] instr, input logic [31:0] pc);
    chk1({nm, " req"}, imem.imem_req, req);
    chk({nm, " addr"}, imem.imem_addr, addr);
    chk1({nm, " valid"}, valid, vld);
    chk({nm, " instr"}, bus.instr, instr);
    chk({nm, " pc"}, bus.pc, pc);
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
    rst2 = 1'b0; imem2.imem_ready = 1'b0; imem2.imem_rvalid = 1'b0; imem2.imem_rdata = 32'h0;
    vt[0]  = '{5'b00000, 32'h0,   32'h0,         1'b0, 32'h0,   1'b0, N,             32'h0};
    vt[1]  = '{5'b10010, 32'h0,   32'h0,         1'b1, 32'h0,   1'b0, N,             32'h0};
    vt[2]  = '{5'b10001, 32'h0,   32'h0010_0093, 1'b0, 32'h4,   1'b0, N,             32'h0};
    vt[3]  = '{5'b10010, 32'h0,   32'h0,         1'b1, 32'h4,   1'b1, 32'h0010_0093, 32'h0};
    vt[4]  = '{5'b10001, 32'h0,   32'h0020_0093, 1'b0, 32'h8,   1'b0, N,             32'h0};
    vt[5]  = '{5'b11010, 32'h0,   32'h0,         1'b1, 32'h8,   1'b1, 32'h0020_0093, 32'h4};
    vt[6]  = '{5'b11001, 32'h0,   32'h0050_0093, 1'b0, 32'hC,   1'b1, 32'h0020_0093, 32'h4};
    vt[7]  = '{5'b11010, 32'h0,   32'h0,         1'b0, 32'hC,   1'b1, 32'h0020_0093, 32'h4};
    vt[8]  = '{5'b10010, 32'h0,   32'h0,         1'b0, 32'hC,   1'b1, 32'h0020_0093, 32'h4};
    vt[9]  = '{5'b11010, 32'h0,   32'h0,         1'b1, 32'hC,   1'b1, 32'h0050_0093, 32'h8};
    vt[10] = '{5'b11110, 32'h103, 32'h0,         1'b0, 32'h10,  1'b1, 32'h0050_0093, 32'h8};
    vt[11] = '{5'b10010, 32'h0,   32'h0,         1'b0, 32'h100, 1'b0, N,             32'h0};
    vt[12] = '{5'b10011, 32'h0,   32'hDEAD_BEEF, 1'b0, 32'h100, 1'b0, N,             32'h0};
    vt[13] = '{5'b10010, 32'h0,   32'h0,         1'b1, 32'h100, 1'b0, N,             32'h0};
    vt[14] = '{5'b10101, 32'h200, 32'hBAD0_0093, 1'b0, 32'h104, 1'b0, N,             32'h0};
    vt[15] = '{5'b10010, 32'h0,   32'h0,         1'b1, 32'h200, 1'b0, N,             32'h0};
    vt[16] = '{5'b10001, 32'h0,   32'h0070_0093, 1'b0, 32'h204, 1'b0, N,             32'h0};
    vt[17] = '{5'b10000, 32'h0,   32'h0,         1'b1, 32'h204, 1'b1, 32'h0070_0093, 32'h200};
    vt[18] = '{5'b10001, 32'h0,   32'hFFFF_FFFF, 1'b1, 32'h204, 1'b0, N,             32'h0};
    vt[19] = '{5'b10000, 32'h0,   32'h0,         1'b1, 32'h204, 1'b0, N,             32'h0};
    drive(5'b00000, 32'h0, 32'h0);
    drive(5'b00000, 32'h0, 32'h0);
    foreach (vt[i]) begin
      drive(vt[i].in, vt[i].rpc, vt[i].rdata);
      chk_out($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].vld, vt[i].instr, vt[i].pc);
    end
    // one-cycle reset while a fetch is outstanding, then a late response
    drive(5'b10010, 32'h0, 32'h0);
    chk_out("rst accept", 1'b1, 32'h204, 1'b0, N, 32'h0);
    drive(5'b00010, 32'h0, 32'h0);
    chk1("rst req low", imem.imem_req, 1'b0);
    drive(5'b10001, 32'h0, 32'hCAFE_0093);
    chk_out("rst state", 1'b1, 32'h0, 1'b0, N, 32'h0);
    drive(5'b10010, 32'h0, 32'h0);
    chk_out("rst late drop", 1'b1, 32'h0, 1'b0, N, 32'h0);
    drive(5'b10001, 32'h0, 32'h0090_0093);
    chk_out("rst refetch", 1'b0, 32'h4, 1'b0, N, 32'h0);
    drive(5'b10000, 32'h0, 32'h0);
    chk_out("rst first word", 1'b1, 32'h4, 1'b1, 32'h0090_0093, 32'h0);
    // pc wrap from the top of the address space
    @(negedge clk); rst2 = 1'b1; imem2.imem_ready = 1'b1; #1;
    chk1("wrap req0", imem2.imem_req, 1'b1);
    chk("wrap addr0", imem2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); imem2.imem_ready = 1'b0; imem2.imem_rvalid = 1'b1; imem2.imem_rdata = 32'h00A0_0093; #1;
    chk("wrap addr1", imem2.imem_addr, 32'h0);
    @(negedge clk); imem2.imem_rvalid = 1'b0; #1;
    chk1("wrap req1", imem2.imem_req, 1'b1);
    chk("wrap addr1 req", imem2.imem_addr, 32'h0);
    chk1("wrap valid", valid2, 1'b1);
    chk("wrap if_id pc", bus2.pc, 32'hFFFF_FFFC);
    // randomized run against an in-order delivery model
    drive(5'b00000, 32'h0, 32'h0);
    mpc = 32'h0; rq_pc = 32'h0; outst = 1'b0; disc = 1'b0; cd = 0;
    p_redir = 1'b1; p_hold = 1'b0; snap = '{instr: N, pc: 32'h0}; snap_v = 1'b0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      s = (c < 2980) && ($urandom_range(0, 3) == 0);
      d = (c < 2980) && ($urandom_range(0, 11) == 0);
      rdy = $urandom_range(0, 3) != 0;
      rv = outst ? (cd == 0) : ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      rdat = $urandom;
      drive({1'b1, s, d, rdy, rv}, rpc, rdat);
      if (p_redir) begin
        chk1("rnd flush valid", valid, 1'b0);
        chk("rnd flush instr", bus.instr, N);
        chk("rnd flush pc", bus.pc, 32'h0);
      end else if (p_hold) begin
        chk1("rnd hold valid", valid, snap_v);
        chk("rnd hold instr", bus.instr, snap.instr);
        chk("rnd hold pc", bus.pc, snap.pc);
      end else begin
        chk1("rnd deliver valid", valid, q.size() != 0);
        if (q.size() != 0) begin
          exp_e = q.pop_front();
          chk("rnd deliver instr", bus.instr, exp_e.instr);
          chk("rnd deliver pc", bus.pc, exp_e.pc);
        end else chk("rnd bubble instr", bus.instr, N);
      end
      chk1("rnd req", imem.imem_req, !outst && q.size() == 0 && !d);
      if (imem.imem_req) chk("rnd addr", imem.imem_addr, mpc);
      snap = bus;
      snap_v = valid;
      p_redir = d;
      p_hold = s && !d;
      if (outst && rv) begin
        outst = 1'b0;
        if (!disc && !d) q.push_back('{instr: rdat, pc: rq_pc});
      end else if (outst) cd--;
      if (d) begin
        q.delete();
        disc = 1'b1;
        mpc = rpc & ~32'h3;
      end
      if (imem.imem_req && rdy) begin
        outst = 1'b1;
        disc = 1'b0;
        rq_pc = mpc;
        mpc += 32'd4;
        cd = $urandom_range(0, 2);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
